// File: rtl/adc_avg_ctrl_if.sv
// Handshake and result bundle between the averaging controller and its environment.
interface adc_avg_ctrl_if #(
    parameter int DATA_W = 12
);
    logic              syncro_i;
    logic              adc_data_req_o;
    logic              adc_data_rdy_i;
    logic [DATA_W-1:0] adc_data_i;
    logic [DATA_W-1:0] data_o;
    logic              data_rdy_o;
    logic              busy_o;
    logic              err_o;
    logic              sync_miss_o;

    modport master (
        input  syncro_i, adc_data_rdy_i, adc_data_i,
        output adc_data_req_o, data_o, data_rdy_o, busy_o, err_o, sync_miss_o
    );

    modport slave (
        output syncro_i, adc_data_rdy_i, adc_data_i,
        input  adc_data_req_o, data_o, data_rdy_o, busy_o, err_o, sync_miss_o
    );
endinterface

// File: rtl/adc_avg_ctrl.sv
// Sync-triggered ADC acquisition: delay, capture 2^LOG2_N samples, output their mean.
// state | meaning
// IDLE  | waiting for a synchronised rising edge on syncro_i
// DELAY | counting DELAY_CYC cycles before requesting conversions
// REQ   | request asserted, accumulating samples on rdy falling edges
// DONE  | registering the averaged result and pulsing data_rdy_o
module adc_avg_ctrl #(
    parameter int DATA_W      = 12,
    parameter int LOG2_N      = 3,
    parameter int DELAY_CYC   = 11,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SIGNED_MODE = 1,
    parameter int ROUND       = 0
) (
    input logic            clk_i,
    input logic            reset_i,
    adc_avg_ctrl_if.master bus
);
    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int DLY_W = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [ACC_W-1:0] RND = (ROUND != 0) ? ACC_W'((1 << LOG2_N) >> 1) : '0;

    typedef enum logic [1:0] {IDLE, DELAY, REQ, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        sync_q;
    logic              rdy_z;
    logic [DLY_W-1:0]  dly_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [CNT_W-1:0]  smp_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  smp_ext;
    logic [ACC_W-1:0]  acc_rnd;
    logic [DATA_W-1:0] result;
    logic              req_q, data_rdy_q, err_q, sync_miss_q;
    logic [DATA_W-1:0] data_q;
    logic              sync_edge, strobe, last_smp, timeout_hit, err_nxt;

    assign sync_edge   = sync_q[1] & ~sync_q[2];
    assign strobe      = rdy_z & ~bus.adc_data_rdy_i;
    assign last_smp    = strobe && (smp_cnt == CNT_W'(N - 1));
    assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == '0);

    always_comb begin
        if (SIGNED_MODE != 0)
            smp_ext = ACC_W'($signed(bus.adc_data_i));
        else
            smp_ext = ACC_W'(bus.adc_data_i);
    end

    // Rounding offset cannot overflow ACC_W: N*max + N/2 stays below 2^ACC_W.
    assign acc_rnd = acc + RND;

    always_comb begin
        if (SIGNED_MODE != 0)
            result = DATA_W'($signed(acc_rnd) >>> LOG2_N);
        else
            result = DATA_W'(acc_rnd >> LOG2_N);
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE:  if (sync_edge) state_nxt = (DELAY_CYC == 0) ? REQ : DELAY;
            DELAY: if (dly_cnt == '0) state_nxt = REQ;
            REQ: begin
                if (last_smp) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
            rdy_z  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], bus.syncro_i};
            rdy_z  <= bus.adc_data_rdy_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dly_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (state == IDLE && sync_edge)
                dly_cnt <= DLY_W'((DELAY_CYC > 0) ? DELAY_CYC - 1 : 0);
            else if (state == DELAY && dly_cnt != '0)
                dly_cnt <= dly_cnt - DLY_W'(1);

            if (state_nxt == REQ && state != REQ)
                to_cnt <= TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
            else if (state == REQ && to_cnt != '0)
                to_cnt <= to_cnt - TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc     <= '0;
            smp_cnt <= '0;
        end else if (state == IDLE && sync_edge) begin
            acc     <= '0;
            smp_cnt <= '0;
        end else if (state == REQ && strobe) begin
            acc     <= acc + smp_ext;
            smp_cnt <= smp_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            req_q       <= 1'b0;
            data_rdy_q  <= 1'b0;
            err_q       <= 1'b0;
            sync_miss_q <= 1'b0;
            data_q      <= '0;
        end else begin
            req_q       <= (state_nxt == REQ);
            data_rdy_q  <= (state == DONE);
            err_q       <= err_nxt;
            sync_miss_q <= sync_edge && (state != IDLE);
            if (state == DONE)
                data_q <= result;
        end
    end

    assign bus.adc_data_req_o = req_q;
    assign bus.data_o         = data_q;
    assign bus.data_rdy_o     = data_rdy_q;
    assign bus.busy_o         = (state != IDLE);
    assign bus.err_o          = err_q;
    assign bus.sync_miss_o    = sync_miss_q;
endmodule

// File: tb/tb_adc_avg_ctrl.sv
// Directed bench: three controller variants driven by one shared ADC stimulus.
module tb_adc_avg_ctrl;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        syncro = 1'b0;
    logic        rdy = 1'b0;
    logic [11:0] adc_data = '0;
    logic [11:0] samp [8];

    int checks = 0, passes = 0, fails = 0;
    int rdy_a = 0, rdy_b = 0, rdy_c = 0;
    int err_a = 0, err_b = 0, err_c = 0;
    int miss_a = 0, miss_b = 0, miss_c = 0;
    int reqh_a = 0, reqh_b = 0, reqh_c = 0;
    int s0, s1, s2, s3, s4, s5, s6, s7, s8;

    always #5 clk_i = ~clk_i;

    adc_avg_ctrl_if #(.DATA_W(12)) ifa ();
    adc_avg_ctrl_if #(.DATA_W(12)) ifb ();
    adc_avg_ctrl_if #(.DATA_W(12)) ifc ();

    assign ifa.syncro_i = syncro;  assign ifa.adc_data_rdy_i = rdy;  assign ifa.adc_data_i = adc_data;
    assign ifb.syncro_i = syncro;  assign ifb.adc_data_rdy_i = rdy;  assign ifb.adc_data_i = adc_data;
    assign ifc.syncro_i = syncro;  assign ifc.adc_data_rdy_i = rdy;  assign ifc.adc_data_i = adc_data;

    // A: signed floor, B: signed rounding with no delay, C: unsigned floor
    adc_avg_ctrl #(.DATA_W(12), .LOG2_N(3), .DELAY_CYC(11), .TIMEOUT_CYC(64), .SIGNED_MODE(1), .ROUND(0))
        dut_a (.clk_i(clk_i), .reset_i(reset_i), .bus(ifa));
    adc_avg_ctrl #(.DATA_W(12), .LOG2_N(3), .DELAY_CYC(0), .TIMEOUT_CYC(64), .SIGNED_MODE(1), .ROUND(1))
        dut_b (.clk_i(clk_i), .reset_i(reset_i), .bus(ifb));
    adc_avg_ctrl #(.DATA_W(12), .LOG2_N(3), .DELAY_CYC(11), .TIMEOUT_CYC(64), .SIGNED_MODE(0), .ROUND(0))
        dut_c (.clk_i(clk_i), .reset_i(reset_i), .bus(ifc));

    always @(posedge clk_i) begin
        if (ifa.data_rdy_o) rdy_a <= rdy_a + 1;
        if (ifb.data_rdy_o) rdy_b <= rdy_b + 1;
        if (ifc.data_rdy_o) rdy_c <= rdy_c + 1;
        if (ifa.err_o) err_a <= err_a + 1;
        if (ifb.err_o) err_b <= err_b + 1;
        if (ifc.err_o) err_c <= err_c + 1;
        if (ifa.sync_miss_o) miss_a <= miss_a + 1;
        if (ifb.sync_miss_o) miss_b <= miss_b + 1;
        if (ifc.sync_miss_o) miss_c <= miss_c + 1;
        if (ifa.adc_data_req_o) reqh_a <= reqh_a + 1;
        if (ifb.adc_data_req_o) reqh_b <= reqh_b + 1;
        if (ifc.adc_data_req_o) reqh_c <= reqh_c + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_sync;
        syncro = 1'b1;
        tick();
        syncro = 1'b0;
        tick();
    endtask

    task automatic send(input logic [11:0] v);
        adc_data = v;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        tick();
    endtask

    task automatic wait_req_a;
        int n = 0;
        while (!ifa.adc_data_req_o && n < 40) begin
            tick();
            n++;
        end
        chk("req_a_rise", ifa.adc_data_req_o, 1);
    endtask

    task automatic run_avg;
        pulse_sync();
        wait_req_a();
        for (int i = 0; i < 8; i++) send(samp[i]);
        tick();
        chk("run_rdy_pulse", ifa.data_rdy_o, 1);
    endtask

    task automatic snap;
        s0 = rdy_a; s1 = rdy_b; s2 = rdy_c;
        s3 = err_a; s4 = err_b; s5 = err_c;
        s6 = reqh_a; s7 = reqh_b; s8 = reqh_c;
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("rst_req", ifa.adc_data_req_o, 0);
        chk("rst_data", ifa.data_o, 0);
        chk("rst_flags", {ifa.data_rdy_o, ifa.busy_o, ifa.err_o, ifa.sync_miss_o}, 0);
        reset_i = 1'b0;
        tick();

        // Run 1: 100..107 with cycle-accurate request timing
        syncro = 1'b1;
        tick();
        syncro = 1'b0;
        tick();
        chk("b_req_before_e2", ifb.adc_data_req_o, 0);
        chk("a_busy_before_e2", ifa.busy_o, 0);
        tick();
        chk("b_req_at_e2", ifb.adc_data_req_o, 1);
        chk("a_busy_at_e2", ifa.busy_o, 1);
        repeat (10) tick();
        chk("a_req_at_e12", ifa.adc_data_req_o, 0);
        tick();
        chk("a_req_at_e13", ifa.adc_data_req_o, 1);
        chk("c_req_at_e13", ifc.adc_data_req_o, 1);
        for (int i = 0; i < 8; i++) send(12'(100 + i));
        chk("a_req_fall_es", ifa.adc_data_req_o, 0);
        chk("a_busy_in_done", ifa.busy_o, 1);
        chk("a_rdy_at_es", ifa.data_rdy_o, 0);
        tick();
        chk("a_rdy_es1", ifa.data_rdy_o, 1);
        chk("a_busy_es1", ifa.busy_o, 0);
        chk("a_avg_100_107", ifa.data_o, 103);
        chk("b_avg_100_107", ifb.data_o, 104);
        chk("c_avg_100_107", ifc.data_o, 103);
        tick();
        chk("a_rdy_one_cycle", ifa.data_rdy_o, 0);
        tick();
        chk("rdy_count_run1", {8'(rdy_a), 8'(rdy_b), 8'(rdy_c)}, 24'h010101);

        // Timeout: only five strobes
        snap();
        pulse_sync();
        wait_req_a();
        for (int i = 0; i < 5; i++) send(12'(i));
        n = 0;
        while (ifa.adc_data_req_o && n < 100) begin
            tick();
            n++;
        end
        chk("to_req_fall", ifa.adc_data_req_o, 0);
        chk("to_err_pulse", ifa.err_o, 1);
        tick();
        chk("to_err_one_cycle", ifa.err_o, 0);
        tick();
        chk("to_req_len_a", reqh_a - s6, 64);
        chk("to_req_len_b", reqh_b - s7, 64);
        chk("to_req_len_c", reqh_c - s8, 64);
        chk("to_err_counts", {8'(err_a - s3), 8'(err_b - s4), 8'(err_c - s5)}, 24'h010101);
        chk("to_no_rdy", {8'(rdy_a - s0), 8'(rdy_b - s1), 8'(rdy_c - s2)}, 0);
        chk("to_hold_a", ifa.data_o, 103);
        chk("to_hold_b", ifb.data_o, 104);

        // Four -1 and four 0: sum -4
        for (int i = 0; i < 8; i++) samp[i] = (i < 4) ? 12'hFFF : 12'h000;
        run_avg();
        chk("mix_a_floor", ifa.data_o, 12'hFFF);
        chk("mix_b_round", ifb.data_o, 12'h000);
        chk("mix_c_unsigned", ifc.data_o, 12'h7FF);
        tick();

        for (int i = 0; i < 8; i++) samp[i] = 12'hFFF;
        run_avg();
        chk("fff_a", ifa.data_o, 12'hFFF);
        chk("fff_b", ifb.data_o, 12'hFFF);
        chk("fff_c_unsigned", ifc.data_o, 12'hFFF);
        tick();

        for (int i = 0; i < 8; i++) samp[i] = 12'h801;
        run_avg();
        chk("x801_a", ifa.data_o, 12'h801);
        chk("x801_b", ifb.data_o, 12'h801);
        chk("x801_c", ifc.data_o, 12'h801);
        tick();

        // Second sync during REQ is reported and ignored
        snap();
        s3 = miss_a; s4 = miss_b; s5 = miss_c;
        pulse_sync();
        wait_req_a();
        for (int i = 0; i < 3; i++) send(12'(i + 1));
        pulse_sync();
        for (int i = 3; i < 8; i++) send(12'(i + 1));
        tick();
        chk("miss_rdy", ifa.data_rdy_o, 1);
        chk("miss_a_avg", ifa.data_o, 4);
        chk("miss_b_avg", ifb.data_o, 5);
        chk("miss_c_avg", ifc.data_o, 4);
        repeat (4) tick();
        chk("miss_counts", {8'(miss_a - s3), 8'(miss_b - s4), 8'(miss_c - s5)}, 24'h010101);
        chk("miss_one_rdy", {8'(rdy_a - s0), 8'(rdy_b - s1), 8'(rdy_c - s2)}, 24'h010101);
        chk("miss_idle", ifa.busy_o, 0);

        // Reset mid-REQ after three strobes
        pulse_sync();
        wait_req_a();
        for (int i = 0; i < 3; i++) send(12'h7FF);
        reset_i = 1'b1;
        #2;
        chk("rst_req_async", {ifa.adc_data_req_o, ifb.adc_data_req_o, ifc.adc_data_req_o}, 0);
        chk("rst_busy_async", ifa.busy_o, 0);
        chk("rst_data_clear", ifa.data_o, 0);
        tick();
        reset_i = 1'b0;
        snap();
        repeat (3) tick();
        chk("rst_no_pulses", {8'(rdy_a - s0), 8'(err_a - s3), 8'(err_b - s4), 8'(err_c - s5)}, 0);
        for (int i = 0; i < 8; i++) samp[i] = 12'(-(i + 1));
        run_avg();
        chk("post_rst_a", ifa.data_o, 12'hFFB);
        chk("post_rst_b", ifb.data_o, 12'hFFC);
        chk("post_rst_c", ifc.data_o, 12'hFFB);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
